serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Upstream stimulus stage for the serial sequence detector.
- Shifts a programmable bit pattern out on dout, one bit per tick. A tick occurs every MCNT clocks, the same time base the detector samples on.
- Supports single-shot or continuous repeat, has a start/busy/done handshake, and can be aborted.
- dout connects directly to the detector's din.

Parameters:
MCNT, 2_500_000, clocks per bit period (tick interval); must be ≥2
CNT_W, 22, tick counter width; must satisfy 2^CNT_W ≥ MCNT
PAT_W, 16, pattern register width (max bits per frame)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  one-cycle request to begin a frame
stop  input  1  abort current frame
pattern  input  PAT_W  bits to send, MSB-first from bit len-1 down to bit 0
len  input  5  number of bits per frame, valid range 1..PAT_W
repeat_en  input  1  1 = loop the frame until stop
tick  output  1  one-cycle pulse when cnt==MCNT-1
dout  output  1  serial bit stream
busy  output  1  high while a frame is armed or shifting
done  output  1  one-cycle pulse when a single-shot frame completes
err  output  1  one-cycle pulse when start is rejected for an invalid len

Behaviour:
- Reset (rst_n=0, async): cnt=0, state=IDLE, dout=0, busy=0, done=0, err=0, all latched registers=0.
- Tick counter:
  - Free-running 0..MCNT-1, then wraps to 0. Never gated by state.
  - tick=1 combinationally when cnt==MCNT-1, keeping this block in phase with the detector's counter after a common reset.
- Latching: on an accepted start, pattern, len and repeat_en are latched. Later changes to these inputs have no effect on the running frame.
- Priority within a cycle: stop > start.
- States (encode one-hot): IDLE, ARM, SHIFT.
- IDLE:
  - dout=0, busy=0.
  - start with 1≤len≤PAT_W and stop=0: latch, busy←1, go ARM.
  - start with len=0 or len>PAT_W: err=1 for one cycle, stay IDLE.
- ARM:
  - Wait for tick.
  - On tick: dout←pat[len-1], idx←len-1, go SHIFT.
- SHIFT, on tick:
  - idx≠0: idx←idx-1, dout←pat[idx-1].
  - idx==0 and repeat: idx←len-1, dout←pat[len-1]. There is no gap between frames.
  - idx==0 and not repeat: dout←0, busy←0, done=1 for one cycle, go IDLE.
- Between ticks, all state and outputs except tick and cnt hold.
- Timing guarantees:
  - Each bit is stable for exactly MCNT clocks.
  - First bit appears at the first tick after acceptance. If start coincides with tick, the first bit appears on the following tick.
- stop:
  - In ARM or SHIFT, stop takes effect on the next clock regardless of tick: dout←0, busy←0, go IDLE, no done pulse.
  - In IDLE, stop has no effect.
- start while busy is ignored; no err pulse.
- len=1: a one-bit frame; done occurs one tick after the bit appears.
- Reset asserted mid-frame: immediate return to reset values. There is no partial done.

Test Plan:
- MCNT=4, pattern=0x000D, len=4, repeat_en=0, start → dout shows 1,1,0,1 for 4 clocks each; then dout=0, done pulses once, busy falls on the same clock. Feeding dout into the detector with the same MCNT gives a detect pulse in the final period.
- Same frame with repeat_en=1 → 1101 repeats back-to-back for 3 frames with no done pulse; stop raised mid-bit → dout=0 and busy=0 on the next clock, no done.
- start with len=0 and with len=17 → err is a single-cycle pulse, busy stays 0, dout stays 0.
- Second start during SHIFT with pattern=0xFFFF → ignored; the in-progress 1101 frame completes unchanged.
- start asserted on the same clock as tick → first bit appears at the next tick, not the current one. len=1 with pattern=0x0001 → a single 1 for MCNT clocks, then done.
- rst_n dropped mid-SHIFT, asynchronous to clk → dout, busy, done and err are 0 immediately; after release cnt restarts at 0 and a fresh start works.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, one bit per
// tick, with start/busy/done handshake, repeat mode and abort.
module serial_pattern_gen #(
  parameter int MCNT  = 2_500_000,
  parameter int CNT_W = 22,
  parameter int PAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [4:0]       len,
  input  logic             repeat_en,
  output logic             tick,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ARM   = 3'b010,
    SHIFT = 3'b100
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PAT_W-1:0] pat_q;
  logic [4:0]       len_q;
  logic             rep_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] top_idx;
  logic             len_ok;

  // Free-running time base, shared phase with the downstream detector.
  assign tick = (cnt == CNT_W'(MCNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

  assign top_idx = IDX_W'(len_q - 5'd1);
  assign len_ok  = (len != 5'd0) && (int'(len) <= PAT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      rep_q <= 1'b0;
      idx   <= '0;
      dout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            if (len_ok) begin
              pat_q <= pattern;
              len_q <= len;
              rep_q <= repeat_en;
              busy  <= 1'b1;
              state <= ARM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ARM: begin
          if (stop) begin
            dout  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            dout  <= pat_q[top_idx];
            idx   <= top_idx;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (stop) begin
            dout  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick) begin
            if (idx != '0) begin
              idx  <= idx - 1'b1;
              dout <= pat_q[idx - 1'b1];
            end else if (rep_q) begin
              // Wrap straight into the next frame with no idle bit.
              idx  <= top_idx;
              dout <= pat_q[top_idx];
            end else begin
              dout  <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          dout  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: table-driven frames, hand-written corner
// sequences and random stimulus against a frame-level reference model.
module tb_serial_pattern_gen;

  localparam int MCNT  = 4;
  localparam int CNT_W = 3;
  localparam int PAT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic        repeat_en = 1'b0;
  logic        tick, dout, busy, done, err;

  int checks = 0;
  int passed = 0;

  serial_pattern_gen #(.MCNT(MCNT), .CNT_W(CNT_W), .PAT_W(PAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pattern),
    .len(len), .repeat_en(repeat_en), .tick(tick), .dout(dout), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset, plus count of bits emitted in the frame.
  int          t;
  bit          m_active;
  int          m_n;
  logic [15:0] m_pat;
  int          m_len;
  bit          m_rep;
  bit          m_dout, m_done, m_err, m_last_tick;

  function automatic void model_reset();
    t = 0; m_active = 0; m_n = 0; m_pat = '0; m_len = 0; m_rep = 0;
    m_dout = 0; m_done = 0; m_err = 0; m_last_tick = 0;
  endfunction

  function automatic bit m_tick();
    return (t % MCNT) == MCNT - 1;
  endfunction

  function automatic void model_step();
    bit tk;
    tk = m_tick();
    m_done = 0;
    m_err  = 0;
    if (!m_active) begin
      if (start && !stop) begin
        if (int'(len) >= 1 && int'(len) <= PAT_W) begin
          m_active = 1; m_n = 0; m_pat = pattern; m_len = int'(len); m_rep = repeat_en;
        end else begin
          m_err = 1;
        end
      end
    end else if (stop) begin
      m_active = 0; m_dout = 0;
    end else if (tk) begin
      m_n++;
      if (!m_rep && m_n > m_len) begin
        m_active = 0; m_dout = 0; m_done = 1;
      end else begin
        m_dout = m_pat[m_len - 1 - ((m_n - 1) % m_len)];
      end
    end
    m_last_tick = tk;
    t++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outputs{tick,dout,busy,done,err}", {27'd0, tick, dout, busy, done, err},
          {27'd0, m_tick(), m_dout, m_active, m_done, m_err});
  endtask

  task automatic run_frame(input logic [15:0] p, input logic [4:0] l, input logic r,
                           input int inject_at, input int max_bits, input int budget,
                           output logic [31:0] bits, output int nbits,
                           output int ndone, output int nerr);
    bits = '0; nbits = 0; ndone = 0; nerr = 0;
    pattern = p; len = l; repeat_en = r; start = 1'b1;
    cyc();
    start = 1'b0;
    if (done) ndone++;
    if (err) nerr++;
    for (int i = 0; i < budget; i++) begin
      if (i == inject_at) begin
        start = 1'b1; pattern = 16'hFFFF; len = 5'd16;
      end
      cyc();
      start = 1'b0;
      if (m_last_tick && busy) begin
        bits = {bits[30:0], dout};
        nbits++;
      end
      if (err) nerr++;
      if (done) begin
        ndone++;
        break;
      end
      if (nbits >= max_bits) break;
    end
  endtask

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic        exp_err;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t        vt[9];
  logic [31:0] bits;
  int          nbits, ndone, nerr, k;

  initial begin
    vt[0] = '{16'h000D, 5'd4,  1'b0, 16'h000D};
    vt[1] = '{16'hA5F0, 5'd16, 1'b0, 16'hA5F0};
    vt[2] = '{16'hFFF2, 5'd3,  1'b0, 16'h0002};
    vt[3] = '{16'h0001, 5'd1,  1'b0, 16'h0001};
    vt[4] = '{16'hFFFE, 5'd1,  1'b0, 16'h0000};
    vt[5] = '{16'h1234, 5'd0,  1'b1, 16'h0000};
    vt[6] = '{16'h1234, 5'd17, 1'b1, 16'h0000};
    vt[7] = '{16'h8000, 5'd16, 1'b0, 16'h8000};
    vt[8] = '{16'hFF55, 5'd9,  1'b0, 16'h0155};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {27'd0, tick, dout, busy, done, err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Table of single-shot frames and rejected lengths.
    foreach (vt[i]) begin
      run_frame(vt[i].pat, vt[i].len, 1'b0, -1, 32,
                vt[i].exp_err ? 6 : (int'(vt[i].len) + 2) * MCNT + 4,
                bits, nbits, ndone, nerr);
      if (vt[i].exp_err) begin
        check($sformatf("vec%0d_err_pulses", i), nerr, 1);
        check($sformatf("vec%0d_no_bits", i), nbits, 0);
      end else begin
        check($sformatf("vec%0d_bits", i), bits, {16'd0, vt[i].exp_bits});
        check($sformatf("vec%0d_nbits", i), nbits, int'(vt[i].len));
        check($sformatf("vec%0d_done", i), ndone, 1);
      end
      cyc();
    end

    // Repeat mode: three back-to-back frames, then abort mid-bit.
    run_frame(16'h000D, 5'd4, 1'b1, -1, 12, 20 * MCNT, bits, nbits, ndone, nerr);
    check("repeat_bits", bits, 32'h0000_0DDD);
    check("repeat_no_done", ndone, 0);
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_dout_busy", {30'd0, dout, busy}, 32'd0);
    k = 0;
    for (int i = 0; i < 2 * MCNT; i++) begin
      cyc();
      if (done) k++;
    end
    check("stop_no_done", k, 0);

    // Second start while shifting is ignored; the running frame is unchanged.
    run_frame(16'h000D, 5'd4, 1'b0, 2 * MCNT, 32, 8 * MCNT, bits, nbits, ndone, nerr);
    check("ignored_start_bits", bits, 32'h0000_000D);
    check("ignored_start_done", ndone, 1);
    check("ignored_start_no_err", nerr, 0);
    cyc();

    // Start on the tick cycle: first bit waits for the following tick.
    k = 0;
    while (!m_tick() && k < 2 * MCNT) begin
      cyc();
      k++;
    end
    check("tick_seen_before_start", tick, 1);
    pattern = 16'h0008; len = 5'd4; repeat_en = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    while (!dout && k < 4 * MCNT) begin
      cyc();
      k++;
    end
    check("start_on_tick_latency", k, MCNT);
    k = 0;
    while (busy && k < 8 * MCNT) begin
      cyc();
      k++;
    end
    check("start_on_tick_finished", busy, 0);

    // Asynchronous reset in the middle of a shifting frame.
    pattern = 16'hFFFF; len = 5'd16; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3 * MCNT; i++) cyc();
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {27'd0, tick, dout, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < MCNT - 1; i++) cyc();
    check("cnt_restart_tick", tick, 1);
    run_frame(16'h000D, 5'd4, 1'b0, -1, 32, 8 * MCNT, bits, nbits, ndone, nerr);
    check("post_reset_bits", bits, 32'h0000_000D);
    check("post_reset_done", ndone, 1);

    // Random stimulus; every cycle is compared against the model.
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      pattern   = 16'($urandom);
      len       = 5'($urandom_range(0, 18));
      repeat_en = ($urandom_range(0, 4) == 0);
      cyc();
    end
    start = 1'b0; stop = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
